// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter that shares the system ID slave (addr 0 = ID, addr 1 = timestamp)
// between NUM_REQ Avalon-MM read masters using an accept -> access -> respond pipeline.
module sysid_read_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int SLAVE_LAT = 1,
   parameter int ID_W      = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_read,
   input  logic [NUM_REQ-1:0] req_address,
   output logic [NUM_REQ-1:0] req_waitrequest,
   output logic [NUM_REQ-1:0] req_readdatavalid,
   output logic [31:0]        req_readdata,
   output logic               slv_address,
   input  logic [31:0]        slv_readdata,
   output logic               busy,
   output logic [ID_W-1:0]    grant_id
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic [2:0] LAT_LAST = 3'(SLAVE_LAT - 1);

   state_t             state_q, state_d;
   logic [2:0]         lat_cnt_q, lat_cnt_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    winner_s;
   logic               slv_addr_q, slv_addr_d;
   logic               win_addr_s;
   logic               found_s;
   logic               take_s;
   logic [31:0]        data_q, data_d;
   logic [NUM_REQ-1:0] rdv_q, rdv_d;
   logic [NUM_REQ-1:0] accept_s;
   logic [NUM_REQ-1:0] grant_oh_s;
   logic               busy_q, busy_d;
   int                 dist_s;
   int                 best_dist_s;

   // Winner is the active requester with the smallest rotated distance from the RR pointer
   always_comb begin
      best_dist_s = NUM_REQ;
      dist_s      = 0;
      take_s      = 1'b0;
      winner_s    = {ID_W{1'b0}};
      win_addr_s  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         dist_s      = (i >= int'(rr_q)) ? (i - int'(rr_q)) : (i + NUM_REQ - int'(rr_q));
         take_s      = req_read[i] && (dist_s < best_dist_s);
         best_dist_s = take_s ? dist_s : best_dist_s;
         winner_s    = take_s ? ID_W'(i) : winner_s;
         win_addr_s  = take_s ? req_address[i] : win_addr_s;
      end
      found_s = (best_dist_s < NUM_REQ);
   end

   // Accept strobe (IDLE only, suppressed in reset) and one-hot of the granted requester
   always_comb begin
      accept_s   = {NUM_REQ{1'b0}};
      grant_oh_s = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         accept_s[i]   = (state_q == IDLE) && !reset && found_s && (winner_s == ID_W'(i));
         grant_oh_s[i] = (grant_q == ID_W'(i));
      end
   end

   assign req_waitrequest = req_read & ~accept_s;

   // Transaction sequencing and next values of all registered outputs
   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      slv_addr_d = slv_addr_q;
      data_d     = data_q;
      rdv_d      = {NUM_REQ{1'b0}};
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               state_d    = ACCESS;
               grant_d    = winner_s;
               slv_addr_d = win_addr_s;
               rr_d       = (winner_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : winner_s + ID_W'(1);
               lat_cnt_d  = 3'd0;
               busy_d     = 1'b1;
            end else begin
               busy_d = 1'b0;
            end
         end
         ACCESS: begin
            if (lat_cnt_q == LAT_LAST) begin
               data_d  = slv_readdata;
               rdv_d   = grant_oh_s;
               state_d = RESPOND;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         RESPOND: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         lat_cnt_q  <= 3'd0;
         rr_q       <= {ID_W{1'b0}};
         grant_q    <= {ID_W{1'b0}};
         slv_addr_q <= 1'b0;
         data_q     <= 32'd0;
         rdv_q      <= {NUM_REQ{1'b0}};
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         slv_addr_q <= slv_addr_d;
         data_q     <= data_d;
         rdv_q      <= rdv_d;
         busy_q     <= busy_d;
      end
   end

   assign req_readdatavalid = rdv_q;
   assign req_readdata      = data_q;
   assign slv_address       = slv_addr_q;
   assign busy              = busy_q;
   assign grant_id          = grant_q;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter: three configurations checked every cycle against a
// transaction-timestamp reference model, plus a vector table and directed corner sequences.
module tb_sysid_read_arbiter;

   logic clk;
   logic rst;

   logic [7:0]  req_rd [3];
   logic [7:0]  req_ad [3];
   logic [31:0] rom    [3][2];
   logic [7:0]  hold   [3];

   logic [1:0]  wr0, rdv0;
   logic [2:0]  wr1, rdv1;
   logic [3:0]  wr2, rdv2;
   logic [31:0] rdata0, rdata1, rdata2;
   logic        slv0, slv1, slv2;
   logic        busy0, busy1, busy2;
   logic [2:0]  gid0, gid1, gid2;
   logic [31:0] sd0, sd1, sd2;

   logic [7:0]  wr_a    [3];
   logic [7:0]  rdv_a   [3];
   logic [31:0] rdata_a [3];
   logic        slv_a   [3];
   logic        busy_a  [3];
   logic [2:0]  gid_a   [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int nr  [3];
   int lat [3];

   // reference model state: timestamps of the last accept, not FSM states
   int          m_acc   [3];
   int          m_rr    [3];
   int          m_grant [3];
   logic        m_slv   [3];
   logic [31:0] m_data  [3];
   logic [7:0]  acc_m   [3];

   int rlog1[$];
   int rlog2[$];
   int busy_cnt2;

   assign sd0 = rom[0][slv0];
   assign sd1 = rom[1][slv1];
   assign sd2 = rom[2][slv2];

   assign wr_a[0] = 8'(wr0);   assign rdv_a[0] = 8'(rdv0);
   assign wr_a[1] = 8'(wr1);   assign rdv_a[1] = 8'(rdv1);
   assign wr_a[2] = 8'(wr2);   assign rdv_a[2] = 8'(rdv2);
   assign rdata_a[0] = rdata0; assign rdata_a[1] = rdata1; assign rdata_a[2] = rdata2;
   assign slv_a[0] = slv0;     assign slv_a[1] = slv1;     assign slv_a[2] = slv2;
   assign busy_a[0] = busy0;   assign busy_a[1] = busy1;   assign busy_a[2] = busy2;
   assign gid_a[0] = gid0;     assign gid_a[1] = gid1;     assign gid_a[2] = gid2;

   sysid_read_arbiter #(.NUM_REQ(2), .SLAVE_LAT(1), .ID_W(3)) u0 (
      .clock(clk), .reset(rst), .req_read(req_rd[0][1:0]), .req_address(req_ad[0][1:0]),
      .req_waitrequest(wr0), .req_readdatavalid(rdv0), .req_readdata(rdata0),
      .slv_address(slv0), .slv_readdata(sd0), .busy(busy0), .grant_id(gid0));

   sysid_read_arbiter #(.NUM_REQ(3), .SLAVE_LAT(2), .ID_W(3)) u1 (
      .clock(clk), .reset(rst), .req_read(req_rd[1][2:0]), .req_address(req_ad[1][2:0]),
      .req_waitrequest(wr1), .req_readdatavalid(rdv1), .req_readdata(rdata1),
      .slv_address(slv1), .slv_readdata(sd1), .busy(busy1), .grant_id(gid1));

   sysid_read_arbiter #(.NUM_REQ(4), .SLAVE_LAT(4), .ID_W(3)) u2 (
      .clock(clk), .reset(rst), .req_read(req_rd[2][3:0]), .req_address(req_ad[2][3:0]),
      .req_waitrequest(wr2), .req_readdatavalid(rdv2), .req_readdata(rdata2),
      .slv_address(slv2), .slv_readdata(sd2), .busy(busy2), .grant_id(gid2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_acc[k]   = -100;
         m_rr[k]    = 0;
         m_grant[k] = 0;
         m_slv[k]   = 1'b0;
         m_data[k]  = 32'd0;
      end
   endtask

   // One clock cycle: compare every instance against the model, advance model, clock, drop accepted requests.
   task automatic step();
      int          L, N, win, idx;
      logic        busy_e, idle;
      logic [7:0]  rdv_e, acc;
      #1;
      for (int k = 0; k < 3; k++) begin
         L      = lat[k];
         N      = nr[k];
         busy_e = (cyc > m_acc[k]) && (cyc <= m_acc[k] + L + 1);
         rdv_e  = (cyc == m_acc[k] + L + 1) ? (8'd1 << m_grant[k]) : 8'd0;
         idle   = (cyc > m_acc[k] + L + 1);
         win    = -1;
         if (idle && !rst) begin
            for (int j = 0; j < N; j++) begin
               idx = (m_rr[k] + j) % N;
               if (win < 0 && req_rd[k][idx]) win = idx;
            end
         end
         acc = (win >= 0) ? (8'd1 << win) : 8'd0;
         chk("waitrequest", k, 32'(wr_a[k]), 32'(req_rd[k] & ~acc));
         chk("readdatavalid", k, 32'(rdv_a[k]), 32'(rdv_e));
         chk("busy", k, 32'(busy_a[k]), 32'(busy_e));
         chk("grant_id", k, 32'(gid_a[k]), 32'(m_grant[k]));
         chk("slv_address", k, 32'(slv_a[k]), 32'(m_slv[k]));
         chk("readdata", k, rdata_a[k], m_data[k]);
         if (rst) begin
            m_acc[k]   = -100;
            m_rr[k]    = 0;
            m_grant[k] = 0;
            m_slv[k]   = 1'b0;
            m_data[k]  = 32'd0;
         end else begin
            if (cyc == m_acc[k] + L) m_data[k] = rom[k][m_slv[k]];
            if (win >= 0) begin
               m_acc[k]   = cyc;
               m_grant[k] = win;
               m_slv[k]   = req_ad[k][win];
               m_rr[k]    = (win + 1) % N;
            end
         end
         acc_m[k] = acc;
      end
      for (int j = 0; j < 8; j++) begin
         if (rdv_a[1][j]) rlog1.push_back(j);
         if (rdv_a[2][j]) rlog2.push_back(j);
      end
      if (busy_a[2]) busy_cnt2++;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) req_rd[k] = req_rd[k] & ~(acc_m[k] & ~hold[k]);
      cyc++;
   endtask

   typedef struct {
      logic [7:0]  req;
      logic [7:0]  wait_e;
      logic [7:0]  rdv_e;
      logic [2:0]  gid_e;
      logic        busy_e;
      logic [31:0] data_e;
   } vec_t;

   vec_t tbl [9];

   initial begin
      nr[0] = 2; nr[1] = 3; nr[2] = 4;
      lat[0] = 1; lat[1] = 2; lat[2] = 4;
      // NUM_REQ=2, SLAVE_LAT=1, both requesters reading continuously from reset
      tbl[0] = '{8'h03, 8'h02, 8'h00, 3'd0, 1'b0, 32'h0000_0000};
      tbl[1] = '{8'h03, 8'h03, 8'h00, 3'd0, 1'b1, 32'h0000_0000};
      tbl[2] = '{8'h03, 8'h03, 8'h01, 3'd0, 1'b1, 32'h0000_0000};
      tbl[3] = '{8'h03, 8'h01, 8'h00, 3'd0, 1'b0, 32'h0000_0000};
      tbl[4] = '{8'h03, 8'h03, 8'h00, 3'd1, 1'b1, 32'h0000_0000};
      tbl[5] = '{8'h03, 8'h03, 8'h02, 3'd1, 1'b1, 32'h5BA8_E010};
      tbl[6] = '{8'h03, 8'h02, 8'h00, 3'd1, 1'b0, 32'h5BA8_E010};
      tbl[7] = '{8'h03, 8'h03, 8'h00, 3'd0, 1'b1, 32'h5BA8_E010};
      tbl[8] = '{8'h03, 8'h03, 8'h01, 3'd0, 1'b1, 32'h0000_0000};

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_rd[k] = 8'h00;
         req_ad[k] = 8'h00;
         hold[k]   = 8'h00;
         rom[k][0] = 32'h0000_0000;
         rom[k][1] = 32'h5BA8_E010;
      end
      busy_cnt2 = 0;
      model_reset();
      @(negedge clk);
      step();
      rst = 1'b0;

      // Single reads, timestamp read and contention
      hold[0] = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         req_rd[0] = tbl[i].req;
         req_ad[0] = 8'h02;
         #1;
         chk("tbl_wait", 0, 32'(wr_a[0]), 32'(tbl[i].wait_e));
         chk("tbl_rdv", 0, 32'(rdv_a[0]), 32'(tbl[i].rdv_e));
         chk("tbl_grant", 0, 32'(gid_a[0]), 32'(tbl[i].gid_e));
         chk("tbl_busy", 0, 32'(busy_a[0]), 32'(tbl[i].busy_e));
         chk("tbl_data", 0, rdata_a[0], tbl[i].data_e);
         step();
      end
      hold[0]   = 8'h00;
      req_rd[0] = 8'h00;
      repeat (4) step();

      // Wrap: pointer moved to 2 by serving requester 1, then 0 and 2 pending
      req_rd[1] = 8'b010;
      req_ad[1] = 8'b000;
      repeat (5) step();
      rlog1.delete();
      req_rd[1] = 8'b101;
      req_ad[1] = 8'b001;
      repeat (10) step();
      chk("wrap_count", 1, 32'(rlog1.size()), 32'd2);
      if (rlog1.size() == 2) begin
         chk("wrap_first", 1, 32'(rlog1[0]), 32'd2);
         chk("wrap_second", 1, 32'(rlog1[1]), 32'd0);
      end

      // SLAVE_LAT=4: slave data changes in the 3rd access cycle
      rom[2][0] = 32'hA5A5_0001;
      req_rd[2] = 8'b0010;
      req_ad[2] = 8'b0000;
      busy_cnt2 = 0;
      step();
      step();
      step();
      rom[2][0] = 32'hC3C3_0003;
      repeat (5) step();
      chk("lat4_busy_cycles", 2, 32'(busy_cnt2), 32'd5);
      chk("lat4_data", 2, rdata_a[2], 32'hC3C3_0003);

      // Reset in the middle of ACCESS
      req_rd[2] = 8'b1000;
      req_ad[2] = 8'b1000;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_busy", 2, 32'(busy_a[2]), 32'd0);
      chk("rst_grant", 2, 32'(gid_a[2]), 32'd0);
      chk("rst_data", 2, rdata_a[2], 32'd0);
      rlog2.delete();
      req_rd[2] = 8'b1001;
      req_ad[2] = 8'b0000;
      repeat (14) step();
      chk("rst_count", 2, 32'(rlog2.size()), 32'd2);
      if (rlog2.size() == 2) begin
         chk("rst_first", 2, 32'(rlog2[0]), 32'd0);
         chk("rst_second", 2, 32'(rlog2[1]), 32'd3);
      end

      // Random traffic, occasional drops, slave data changes and resets
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < nr[k]; j++) begin
               if (!req_rd[k][j]) begin
                  if ($urandom_range(0, 2) == 0) begin
                     req_rd[k][j] = 1'b1;
                     req_ad[k][j] = 1'($urandom_range(0, 1));
                  end
               end else if ($urandom_range(0, 63) == 0) begin
                  req_rd[k][j] = 1'b0;
               end
            end
            if ($urandom_range(0, 7) == 0) rom[k][1'($urandom_range(0, 1))] = $urandom;
         end
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
